// File: rtl/seq_count_monitor_pkg.sv
// Shared types and expected-value arithmetic for the counter sequence monitor.
package seq_count_monitor_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CHECK = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISMATCH = 2'b01,
        FC_TIMEOUT  = 2'b10
    } fail_code_t;

    // Caller truncates to its bus width, which yields the modulo-2^WIDTH result.
    function automatic logic [31:0] next_exp(input logic [31:0] value,
                                             input logic [31:0] step,
                                             input logic        dir_up);
        return dir_up ? value + step : value - step;
    endfunction

endpackage

// File: rtl/seq_count_monitor_if.sv
// Monitor-side bus: observed count, trigger, and registered pass/fail reporting.
interface seq_count_monitor_if #(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned RUN_LEN = 3,
    parameter int unsigned ECW     = 8
);
    import seq_count_monitor_pkg::*;

    localparam int unsigned IDXW = $clog2(RUN_LEN + 1);

    logic             mon_en;
    logic             smp_valid;
    logic [WIDTH-1:0] cnt_in;
    logic [WIDTH-1:0] start_val;
    logic             busy;
    logic             pass;
    logic             fail;
    fail_code_t       fail_code;
    logic [WIDTH-1:0] fail_exp;
    logic [WIDTH-1:0] fail_got;
    logic [IDXW-1:0]  fail_idx;
    logic [ECW-1:0]   err_cnt;

    modport master (
        output mon_en, smp_valid, cnt_in, start_val,
        input  busy, pass, fail, fail_code, fail_exp, fail_got, fail_idx, err_cnt
    );

    modport slave (
        input  mon_en, smp_valid, cnt_in, start_val,
        output busy, pass, fail, fail_code, fail_exp, fail_got, fail_idx, err_cnt
    );

endinterface

// File: rtl/seq_count_monitor_gap_timer.sv
// Counts consecutive sample-less CHECK cycles; expired flags the cycle that reaches MAX_GAP.
module seq_count_monitor_gap_timer #(
    parameter int unsigned MAX_GAP = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic expired
);
    localparam int unsigned GW = $clog2(MAX_GAP + 1);

    logic [GW-1:0] gap;

    assign expired = tick && (gap == GW'(MAX_GAP - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            gap <= '0;
        end else if (clr) begin
            gap <= '0;
        end else if (tick && (gap != GW'(MAX_GAP))) begin
            gap <= gap + GW'(1);
        end
    end

endmodule

// File: rtl/seq_count_monitor.sv
// Arms on a trigger count, then checks RUN_LEN valid samples step by STEP (mod 2^WIDTH).
// Define SEQ_COUNT_MONITOR_SVA_EN to compile in the concurrent assertions and covers.
module seq_count_monitor
    import seq_count_monitor_pkg::*;
#(
    parameter int unsigned WIDTH   = 3,
    parameter int unsigned RUN_LEN = 3,
    parameter int unsigned STEP    = 1,
    parameter bit          DIR_UP  = 1'b1,
    parameter int unsigned MAX_GAP = 8,
    parameter int unsigned ECW     = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_count_monitor_if.slave bus
);
    localparam int unsigned IDXW = $clog2(RUN_LEN + 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] exp_q, exp_n;
    logic [IDXW-1:0]  idx, idx_n;
    logic             pass_n, fail_n;
    fail_code_t       code_n;
    logic [WIDTH-1:0] fexp_n, fgot_n;
    logic [IDXW-1:0]  fidx_n;
    logic [ECW-1:0]   err_n;
    logic [WIDTH-1:0] step_val, start_step;
    logic             trigger, tick, clr, expired;

    assign step_val   = WIDTH'(next_exp(32'(exp_q), STEP, DIR_UP));
    assign start_step = WIDTH'(next_exp(32'(bus.start_val), STEP, DIR_UP));
    assign trigger    = bus.mon_en && bus.smp_valid && (bus.cnt_in == bus.start_val);
    assign tick       = (state == CHECK) && !bus.smp_valid;
    assign clr        = !tick;

    seq_count_monitor_gap_timer #(.MAX_GAP(MAX_GAP)) u_gap (
        .clk     (clk),
        .rst     (rst),
        .clr     (clr),
        .tick    (tick),
        .expired (expired)
    );

    // Next-state and next-output decode; mon_en low wins over any same-cycle sample.
    always_comb begin
        state_n = state;
        exp_n   = exp_q;
        idx_n   = idx;
        pass_n  = 1'b0;
        fail_n  = 1'b0;
        code_n  = bus.fail_code;
        fexp_n  = bus.fail_exp;
        fgot_n  = bus.fail_got;
        fidx_n  = bus.fail_idx;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_n = CHECK;
                    exp_n   = start_step;
                    idx_n   = IDXW'(1);
                end
            end
            CHECK: begin
                if (!bus.mon_en) begin
                    state_n = IDLE;
                end else if (bus.smp_valid) begin
                    if (bus.cnt_in == exp_q) begin
                        if (idx == IDXW'(RUN_LEN)) begin
                            pass_n  = 1'b1;
                            state_n = IDLE;
                        end else begin
                            exp_n = step_val;
                            idx_n = idx + IDXW'(1);
                        end
                    end else begin
                        fail_n  = 1'b1;
                        code_n  = FC_MISMATCH;
                        fexp_n  = exp_q;
                        fgot_n  = bus.cnt_in;
                        fidx_n  = idx;
                        state_n = IDLE;
                    end
                end else if (expired) begin
                    fail_n  = 1'b1;
                    code_n  = FC_TIMEOUT;
                    fexp_n  = exp_q;
                    fgot_n  = '0;
                    fidx_n  = idx;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        err_n = (fail_n && (bus.err_cnt != '1)) ? bus.err_cnt + ECW'(1) : bus.err_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            exp_q         <= '0;
            idx           <= '0;
            bus.busy      <= 1'b0;
            bus.pass      <= 1'b0;
            bus.fail      <= 1'b0;
            bus.fail_code <= FC_NONE;
            bus.fail_exp  <= '0;
            bus.fail_got  <= '0;
            bus.fail_idx  <= '0;
            bus.err_cnt   <= '0;
        end else begin
            state         <= state_n;
            exp_q         <= exp_n;
            idx           <= idx_n;
            bus.busy      <= (state_n == CHECK);
            bus.pass      <= pass_n;
            bus.fail      <= fail_n;
            bus.fail_code <= code_n;
            bus.fail_exp  <= fexp_n;
            bus.fail_got  <= fgot_n;
            bus.fail_idx  <= fidx_n;
            bus.err_cnt   <= err_n;
        end
    end

`ifdef SEQ_COUNT_MONITOR_SVA_EN
    a_no_pass_and_fail: assert property (@(posedge clk) disable iff (rst)
        !(bus.pass && bus.fail));
    a_fail_has_code: assert property (@(posedge clk) disable iff (rst)
        bus.fail |-> (bus.fail_code != FC_NONE));
    a_busy_after_trigger: assert property (@(posedge clk) disable iff (rst)
        $rose(bus.busy) |-> $past(trigger));
    a_err_monotonic: assert property (@(posedge clk) disable iff (rst)
        !$past(rst) |-> (bus.err_cnt >= $past(bus.err_cnt)));
    a_trigger_arms: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE && trigger) |=>
        (bus.busy && exp_q == WIDTH'(next_exp(32'($past(bus.start_val)), STEP, DIR_UP))));
    a_sample_steps: assert property (@(posedge clk) disable iff (rst)
        (state == CHECK && bus.mon_en && bus.smp_valid && bus.cnt_in == exp_q &&
         idx != IDXW'(RUN_LEN)) |=>
        (exp_q == WIDTH'(next_exp(32'($past(exp_q)), STEP, DIR_UP)) &&
         idx == $past(idx) + IDXW'(1)));
    c_pass:     cover property (@(posedge clk) disable iff (rst) bus.pass);
    c_mismatch: cover property (@(posedge clk) disable iff (rst)
        bus.fail && bus.fail_code == FC_MISMATCH);
    c_timeout:  cover property (@(posedge clk) disable iff (rst)
        bus.fail && bus.fail_code == FC_TIMEOUT);
    c_wrap:     cover property (@(posedge clk) disable iff (rst)
        state == CHECK && bus.mon_en && bus.smp_valid && bus.cnt_in == exp_q &&
        (DIR_UP ? (step_val < exp_q) : (step_val > exp_q)));
`endif

endmodule

// File: tb/tb_seq_count_monitor.sv
// Scoreboard bench: three monitor instances (up, down, 2-bit error counter) share stimulus.
module tb_seq_count_monitor;

    typedef struct {
        int cyc;
        int is_fail;
        int code;
        int fexp;
        int fgot;
        int fidx;
        int err;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   sel = 0;
    ev_t  qa[$];
    ev_t  qb[$];
    ev_t  qc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_count_monitor_if #(.WIDTH(3), .RUN_LEN(3), .ECW(8)) ifa ();
    seq_count_monitor_if #(.WIDTH(3), .RUN_LEN(3), .ECW(8)) ifb ();
    seq_count_monitor_if #(.WIDTH(3), .RUN_LEN(3), .ECW(2)) ifc ();

    seq_count_monitor #(.WIDTH(3), .RUN_LEN(3), .STEP(1), .DIR_UP(1'b1), .MAX_GAP(4), .ECW(8))
        dut_a (.clk(clk), .rst(rst), .bus(ifa));
    seq_count_monitor #(.WIDTH(3), .RUN_LEN(3), .STEP(1), .DIR_UP(1'b0), .MAX_GAP(4), .ECW(8))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));
    seq_count_monitor #(.WIDTH(3), .RUN_LEN(3), .STEP(1), .DIR_UP(1'b1), .MAX_GAP(4), .ECW(2))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    function automatic int cur_busy();
        case (sel)
            0:       return int'(ifa.busy);
            1:       return int'(ifb.busy);
            default: return int'(ifc.busy);
        endcase
    endfunction

    // Drive one cycle of inputs on the falling edge; optionally check busy just after the rising edge.
    task automatic put(input logic en, input logic v, input int val, input int exp_busy);
        @(negedge clk);
        ifa.mon_en = en && (sel == 0);
        ifb.mon_en = en && (sel == 1);
        ifc.mon_en = en && (sel == 2);
        ifa.smp_valid = v;
        ifb.smp_valid = v;
        ifc.smp_valid = v;
        ifa.cnt_in = 3'(val);
        ifb.cnt_in = 3'(val);
        ifc.cnt_in = 3'(val);
        @(posedge clk);
        #1;
        if (exp_busy >= 0) chk("busy", cur_busy(), exp_busy);
    endtask

    task automatic set_start(input int s);
        ifa.start_val = 3'(s);
        ifb.start_val = 3'(s);
        ifc.start_val = 3'(s);
    endtask

    task automatic push(input ev_t e);
        case (sel)
            0:       qa.push_back(e);
            1:       qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic exp_pass(input int err);
        ev_t e = '{cyc: cyc, is_fail: 0, code: 0, fexp: 0, fgot: 0, fidx: 0, err: err};
        push(e);
    endtask

    task automatic exp_fail(input int code, input int fexp, input int fgot, input int fidx,
                            input int err);
        ev_t e = '{cyc: cyc, is_fail: 1, code: code, fexp: fexp, fgot: fgot, fidx: fidx, err: err};
        push(e);
    endtask

    task automatic score(input string nm, input ev_t e, input int p, input int f, input int code,
                         input int fexp, input int fgot, input int fidx, input int err);
        chk({nm, "_cycle"}, cyc, e.cyc);
        chk({nm, "_pass"}, p, (e.is_fail != 0) ? 0 : 1);
        chk({nm, "_fail"}, f, e.is_fail);
        chk({nm, "_err_cnt"}, err, e.err);
        if (e.is_fail != 0) begin
            chk({nm, "_fail_code"}, code, e.code);
            chk({nm, "_fail_exp"}, fexp, e.fexp);
            chk({nm, "_fail_got"}, fgot, e.fgot);
            chk({nm, "_fail_idx"}, fidx, e.fidx);
        end
    endtask

    always @(negedge clk) begin
        if (ifa.pass || ifa.fail) begin
            if (qa.size() == 0) chk("a_unexpected_pulse", 1, 0);
            else score("a", qa.pop_front(), int'(ifa.pass), int'(ifa.fail), int'(ifa.fail_code),
                       int'(ifa.fail_exp), int'(ifa.fail_got), int'(ifa.fail_idx), int'(ifa.err_cnt));
        end
    end

    always @(negedge clk) begin
        if (ifb.pass || ifb.fail) begin
            if (qb.size() == 0) chk("b_unexpected_pulse", 1, 0);
            else score("b", qb.pop_front(), int'(ifb.pass), int'(ifb.fail), int'(ifb.fail_code),
                       int'(ifb.fail_exp), int'(ifb.fail_got), int'(ifb.fail_idx), int'(ifb.err_cnt));
        end
    end

    always @(negedge clk) begin
        if (ifc.pass || ifc.fail) begin
            if (qc.size() == 0) chk("c_unexpected_pulse", 1, 0);
            else score("c", qc.pop_front(), int'(ifc.pass), int'(ifc.fail), int'(ifc.fail_code),
                       int'(ifc.fail_exp), int'(ifc.fail_got), int'(ifc.fail_idx), int'(ifc.err_cnt));
        end
    end

    task automatic chk_a_cleared(input string nm);
        chk({nm, "_busy"}, int'(ifa.busy), 0);
        chk({nm, "_pass"}, int'(ifa.pass), 0);
        chk({nm, "_fail"}, int'(ifa.fail), 0);
        chk({nm, "_fail_code"}, int'(ifa.fail_code), 0);
        chk({nm, "_fail_exp"}, int'(ifa.fail_exp), 0);
        chk({nm, "_fail_got"}, int'(ifa.fail_got), 0);
        chk({nm, "_fail_idx"}, int'(ifa.fail_idx), 0);
        chk({nm, "_err_cnt"}, int'(ifa.err_cnt), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ifa.mon_en = 1'b0; ifa.smp_valid = 1'b0; ifa.cnt_in = '0;
        ifb.mon_en = 1'b0; ifb.smp_valid = 1'b0; ifb.cnt_in = '0;
        ifc.mon_en = 1'b0; ifc.smp_valid = 1'b0; ifc.cnt_in = '0;
        set_start(0);
        repeat (2) @(posedge clk);
        #1;
        chk_a_cleared("reset_a");
        chk("reset_b_err_cnt", int'(ifb.err_cnt), 0);
        chk("reset_c_err_cnt", int'(ifc.err_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        // Instance A: clean run, mismatch, wrap, trigger-as-data, timeout, abort.
        sel = 0;
        put(1, 1, 0, 1); put(1, 1, 1, 1); put(1, 1, 2, 1); put(1, 1, 3, 0);
        exp_pass(0);
        put(1, 1, 0, 1); put(1, 1, 1, 1); put(1, 1, 4, 0);
        exp_fail(1, 2, 4, 2, 1);
        set_start(6);
        put(1, 1, 6, 1); put(1, 1, 7, 1); put(1, 1, 0, 1); put(1, 1, 1, 0);
        exp_pass(1);
        set_start(2);
        put(1, 1, 2, 1); put(1, 1, 3, 1); put(1, 1, 2, 0);
        exp_fail(1, 4, 2, 2, 2);
        put(1, 1, 2, 1); put(1, 1, 3, 1); put(1, 1, 4, 1); put(1, 1, 5, 0);
        exp_pass(2);
        set_start(0);
        put(1, 1, 0, 1); put(1, 1, 1, 1);
        put(1, 0, 0, 1); put(1, 0, 0, 1); put(1, 0, 0, 1); put(1, 0, 0, 0);
        exp_fail(2, 2, 0, 2, 3);
        put(1, 1, 0, 1); put(1, 1, 1, 1);
        put(0, 1, 2, 0);
        put(0, 1, 0, 0);
        put(1, 1, 3, 0);
        chk("held_fail_code", int'(ifa.fail_code), 2);
        chk("held_fail_exp", int'(ifa.fail_exp), 2);
        chk("held_fail_got", int'(ifa.fail_got), 0);
        chk("held_fail_idx", int'(ifa.fail_idx), 2);
        chk("held_err_cnt", int'(ifa.err_cnt), 3);

        // Instance B counts down through the wrap.
        sel = 1;
        set_start(1);
        put(1, 1, 1, 1); put(1, 1, 0, 1); put(1, 1, 7, 1); put(1, 1, 6, 0);
        exp_pass(0);

        // Instance C: 2-bit error counter saturates while fail keeps pulsing.
        sel = 2;
        set_start(0);
        for (int k = 1; k <= 4; k++) begin
            put(1, 1, 0, 1); put(1, 1, 5, 0);
            exp_fail(1, 1, 5, 1, (k < 3) ? k : 3);
        end

        // Instance A: reset in the middle of a check, alongside a would-be matching sample.
        sel = 0;
        put(1, 1, 0, 1); put(1, 1, 1, 1);
        @(negedge clk);
        rst = 1'b1;
        ifa.cnt_in = 3'd2;
        @(posedge clk);
        #1;
        chk_a_cleared("mid_check_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) put(1, 0, 0, -1);

        chk("a_pending", qa.size(), 0);
        chk("b_pending", qb.size(), 0);
        chk("c_pending", qc.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_count_monitor.md
Name: seq_count_monitor

Overview:
Parametrised, synthesisable hardware sequence checker for any counter bus in the design. It arms when the monitored count equals a runtime trigger value. It then checks that the next RUN_LEN valid samples advance by STEP, modulo 2^WIDTH, up or down. It reports a pass/fail pulse, captures fail details and keeps a saturating error count, so the check also runs in silicon and emulation, not only in simulation.

Parameters:
WIDTH, 3, width of monitored count bus
RUN_LEN, 3, number of post-trigger samples checked (>=1)
STEP, 1, expected increment magnitude (1..2^WIDTH-1)
DIR_UP, 1, 1 = expected += STEP, 0 = expected -= STEP
MAX_GAP, 8, max consecutive cycles without smp_valid while checking (>=1)
ECW, 8, width of error counter

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
mon_en  in  1  monitor enable
smp_valid  in  1  cnt_in valid this cycle
cnt_in  in  WIDTH  monitored count value
start_val  in  WIDTH  trigger value
busy  out  1  high while in CHECK
pass  out  1  one-cycle pulse, sequence completed
fail  out  1  one-cycle pulse, sequence broken
fail_code  out  2  01 mismatch, 10 timeout; held until next fail
fail_exp  out  WIDTH  expected value at failure; held
fail_got  out  WIDTH  received value at failure (0 on timeout); held
fail_idx  out  $clog2(RUN_LEN+1)  index of failing sample (1..RUN_LEN); held
err_cnt  out  ECW  total fails, saturating at all-ones

Behaviour:
- Reset (sync, rst=1 at clk edge): state IDLE. All outputs 0. Internal expected value, idx and gap timer 0. Reset overrides everything, including mid-CHECK, and produces no pass/fail pulse.
- States: IDLE, CHECK. All outputs are registered. busy = (state==CHECK).
- IDLE -> CHECK when mon_en && smp_valid && cnt_in==start_val. On entry: exp = start_val ± STEP, idx = 1, gap = 0.
- CHECK, smp_valid=1:
  - cnt_in==exp and idx==RUN_LEN: pass pulse next cycle, go IDLE.
  - cnt_in==exp otherwise: exp ± STEP, idx+1, gap = 0.
  - cnt_in!=exp: fail pulse with code 01; capture exp, cnt_in and idx; err_cnt+1; go IDLE.
- CHECK, smp_valid=0: gap+1. When gap reaches MAX_GAP: fail with code 10; fail_exp = exp, fail_got = 0, fail_idx = idx; err_cnt+1; go IDLE.
- CHECK, mon_en=0: abort to IDLE. No pulse, no capture, err_cnt unchanged. mon_en low takes priority over a same-cycle sample.
- Latency: pass/fail assert exactly 1 cycle after the deciding sample edge.
- Arithmetic: exp is computed modulo 2^WIDTH. Wrap-around is legal (WIDTH=3: 7 -> 0 up, 0 -> 7 down).
- No overlap: a trigger value seen while in CHECK is checked as data only. The cycle that returns to IDLE never retriggers. The earliest retrigger is the next valid sample.
- err_cnt saturates: at all-ones it holds and fail still pulses.
- mon_en=0 in IDLE: no arming. Held fail_* fields keep their values.

Optional Feature:
SEQ_COUNT_MONITOR_SVA_EN
- Defined: compile in concurrent assertions on clk, disabled iff rst:
  - pass and fail are never both high.
  - fail implies a non-zero fail_code.
  - busy rises only after a trigger sample.
  - err_cnt never decreases.
  - A property mirroring the checked sequence: trigger |=> exp stepped over RUN_LEN samples.
  - Cover properties for pass, mismatch, timeout and wrap.
- Undefined: no assertion or cover code. RTL behaviour is identical either way.

Decomposition:
- Package seq_count_monitor_pkg:
  - state enum {IDLE, CHECK}.
  - fail-code enum {FC_NONE=2'b00, FC_MISMATCH=2'b01, FC_TIMEOUT=2'b10}.
  - function next_exp(value, step, dir_up) returning the modulo result.
- One sub-module: seq_count_monitor_gap_timer.
  - Parameter MAX_GAP.
  - Inputs clr and tick (tick = CHECK && !smp_valid); output expired.
  - Sync reset, same clk/rst.

Test Plan (WIDTH=3, RUN_LEN=3, STEP=1, DIR_UP=1, MAX_GAP=4, start_val=0 unless noted):
- Samples 0,1,2,3 every cycle -> busy high 3 cycles, pass=1 one cycle after sample 3, err_cnt=0.
- Samples 0,1,4 (forced jump) -> fail, fail_code=01, fail_exp=2, fail_got=4, fail_idx=2, err_cnt=1.
- start_val=6, samples 6,7,0,1 -> pass (wrap accepted). DIR_UP=0, start_val=1, samples 1,0,7,6 -> pass.
- Samples 0,1, then smp_valid=0 for 4 cycles -> fail, fail_code=10, fail_exp=2, fail_got=0, fail_idx=2.
- ECW=2, four mismatch sequences -> err_cnt 1,2,3,3; fourth fail still pulses.
- mon_en dropped after sample 1 -> busy=0 next cycle, no pass/fail. Separately, rst mid-CHECK -> all outputs 0 next cycle, err_cnt=0.
